axis_ifft_sample_serializer: RTL and testbench

//  Downstream neighbour of the 8-point IFFT stage. Accepts one 64-bit AXI-Stream beat (8 signed 8-bit time samples x0..x7).

---
 rtl/ifft_pkg.sv | 29 ++
 rtl/axis_word_hold_reg.sv | 47 ++++
 rtl/axis_ifft_sample_serializer.sv | 178 +++++++++++++++++
 tb/tb_axis_ifft_sample_serializer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifft_pkg
// Description : Shared constants and types for the 8-point IFFT datapath and
//               its downstream serializer. The IFFT output width is built
//               from the same constants, so both sides always agree on the
//               word layout {x7,...,x0} with x0 in the least significant
//               byte.
// Contents    : SAMPLE_WIDTH, SAMPLES_PER_BEAT, IFFT_OUT_WIDTH,
//               sample_t, ifft_word_t, to_offset_binary()
// Revision    : 1.0 - initial release
// ============================================================================
package ifft_pkg;

    localparam int SAMPLE_WIDTH     = 8;
    localparam int SAMPLES_PER_BEAT = 8;
    localparam int IFFT_OUT_WIDTH   = SAMPLE_WIDTH * SAMPLES_PER_BEAT;

    typedef logic [SAMPLE_WIDTH-1:0]   sample_t;
    typedef logic [IFFT_OUT_WIDTH-1:0] ifft_word_t;

    // Two's complement -> offset binary: flipping the sign bit maps
    // -128 -> 0x00, 0 -> 0x80 and 127 -> 0xFF for an unsigned DAC.
    function automatic sample_t to_offset_binary(input sample_t s);
        return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
    endfunction

endpackage : ifft_pkg
`default_nettype wire

// File: rtl/axis_word_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_word_hold_reg
// Description : One-entry holding register with a valid flag. A load
//               captures i_data and sets valid; an unload clears valid.
//               Load wins over unload, so a same-cycle load+unload replaces
//               the entry and stays valid.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_load        - capture i_data into the entry
//               i_data        - word to capture
//               i_unload      - entry consumed this cycle
//               o_valid       - entry holds a word
//               o_data        - stored word
// Revision    : 1.0 - initial release
// ============================================================================
module axis_word_hold_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_unload,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : axis_word_hold_reg
`default_nettype wire

// File: rtl/axis_ifft_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module      : axis_ifft_sample_serializer
// Description : Takes one 64-bit AXI-Stream word (eight signed 8-bit time
//               samples x0..x7 from the IFFT) and emits them as eight
//               byte-wide AXI-Stream beats, x0 first. tlast marks the final
//               sample of every FRAMES_PER_PACKET input words. A shift stage
//               plus a one-word hold stage let the output run at one sample
//               per cycle with no bubble between words.
// Config      : `define IFFT_SERIALIZER_OFFSET_BINARY_EN to emit samples in
//               offset binary (sign bit inverted) instead of two's
//               complement. Handshake and timing are identical either way.
// Ports       : s_axis_aclk    - single clock for both interfaces
//               s_axis_areset  - asynchronous active-high reset
//               s_axis_tvalid/tready/tdata - 64-bit input word stream
//               m_axis_tvalid/tready/tdata/tlast/tkeep - 8-bit sample stream
// Revision    : 1.0 - initial release
// ============================================================================
module axis_ifft_sample_serializer
    import ifft_pkg::*;
#(
    parameter int FRAMES_PER_PACKET = 16
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_areset,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [IFFT_OUT_WIDTH-1:0] s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [SAMPLE_WIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tkeep
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int c_IDX_W = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1;
    localparam int c_PKT_W = (FRAMES_PER_PACKET > 1) ? $clog2(FRAMES_PER_PACKET) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(SAMPLES_PER_BEAT - 1);
    localparam logic [c_PKT_W-1:0] c_PKT_LAST = c_PKT_W'(FRAMES_PER_PACKET - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ifft_word_t           r_shift;
    logic                 r_shift_valid;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_PKT_W-1:0]   r_pkt_cnt;
    logic                 r_ready_en;

    logic                 w_hold_valid;
    ifft_word_t           w_hold_data;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_word_done;
    logic                 w_shift_free;
    logic                 w_hold_to_shift;
    logic                 w_in_to_shift;
    logic                 w_in_to_hold;

    sample_t              w_lane [SAMPLES_PER_BEAT];
    sample_t              w_sample;
    sample_t              w_sample_out;

    // ------------------------------------------------------------------
    // Handshakes and refill decisions
    // ------------------------------------------------------------------
    assign w_in_fire   = s_axis_tvalid & s_axis_tready;
    assign w_out_fire  = r_shift_valid & m_axis_tready;
    assign w_word_done = w_out_fire & (r_idx == c_IDX_LAST);

    // The shift stage can take a new word in the same cycle its last sample
    // leaves, which is what removes the bubble between consecutive words.
    assign w_shift_free    = ~r_shift_valid | w_word_done;
    assign w_hold_to_shift = w_shift_free & w_hold_valid;
    assign w_in_to_shift   = w_shift_free & ~w_hold_valid & w_in_fire;
    assign w_in_to_hold    = w_in_fire & ~w_in_to_shift;

    // Ready depends only on flops, never on m_axis_tready. r_ready_en keeps
    // it low while reset is asserted (the hold flag alone would read empty).
    assign s_axis_tready = r_ready_en & ~w_hold_valid;

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hold stage (next word)
    // ------------------------------------------------------------------
    axis_word_hold_reg #(
        .WIDTH    (IFFT_OUT_WIDTH)
    ) u_hold (
        .clk      (s_axis_aclk),
        .rst      (s_axis_areset),
        .i_load   (w_in_to_hold),
        .i_data   (s_axis_tdata),
        .i_unload (w_hold_to_shift),
        .o_valid  (w_hold_valid),
        .o_data   (w_hold_data)
    );

    // ------------------------------------------------------------------
    // Shift stage (current word)
    // ------------------------------------------------------------------
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_shift       <= '0;
            r_shift_valid <= 1'b0;
        end else if (w_hold_to_shift) begin
            r_shift       <= w_hold_data;
            r_shift_valid <= 1'b1;
        end else if (w_in_to_shift) begin
            r_shift       <= s_axis_tdata;
            r_shift_valid <= 1'b1;
        end else if (w_word_done) begin
            r_shift_valid <= 1'b0;
        end
    end

    // Sample index within the current word; wraps to 0 after the last lane.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_idx <= '0;
        end else if (w_word_done) begin
            r_idx <= '0;
        end else if (w_out_fire) begin
            r_idx <= r_idx + c_IDX_W'(1);
        end
    end

    // Word count within the packet; advances once per completed word.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_pkt_cnt <= '0;
        end else if (w_word_done) begin
            if (r_pkt_cnt == c_PKT_LAST) begin
                r_pkt_cnt <= '0;
            end else begin
                r_pkt_cnt <= r_pkt_cnt + c_PKT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SAMPLES_PER_BEAT; gi++) begin : g_lane
            assign w_lane[gi] = r_shift[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    endgenerate

    assign w_sample = w_lane[r_idx];

`ifdef IFFT_SERIALIZER_OFFSET_BINARY_EN
    assign w_sample_out = to_offset_binary(w_sample);
`else
    assign w_sample_out = w_sample;
`endif

    // Data is forced to zero when no word is loaded so that the bus reads
    // 0 in reset in both number formats.
    assign m_axis_tvalid = r_shift_valid;
    assign m_axis_tdata  = r_shift_valid ? w_sample_out : '0;
    assign m_axis_tlast  = r_shift_valid & (r_idx == c_IDX_LAST) & (r_pkt_cnt == c_PKT_LAST);
    assign m_axis_tkeep  = 1'b1;

endmodule : axis_ifft_sample_serializer
`default_nettype wire

// File: tb/tb_axis_ifft_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_ifft_sample_serializer
// Description : Self-checking bench for axis_ifft_sample_serializer. Two
//               instances (FRAMES_PER_PACKET = 16 and = 1) share stimulus;
//               `sel` chooses which one is observed. A sample-queue model
//               predicts every output beat, tlast, tvalid and tready.
// Config      : honours IFFT_SERIALIZER_OFFSET_BINARY_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_ifft_sample_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [63:0] s_tdata = '0;
    logic        m_tready = 1'b0;

    logic        a_s_tready, a_m_tvalid, a_m_tlast, a_m_tkeep;
    logic [7:0]  a_m_tdata;
    logic        b_s_tready, b_m_tvalid, b_m_tlast, b_m_tkeep;
    logic [7:0]  b_m_tdata;

    bit          sel = 1'b0;
    logic        o_s_tready, o_m_tvalid, o_m_tlast, o_m_tkeep;
    logic [7:0]  o_m_tdata;

    assign o_s_tready = sel ? b_s_tready : a_s_tready;
    assign o_m_tvalid = sel ? b_m_tvalid : a_m_tvalid;
    assign o_m_tlast  = sel ? b_m_tlast  : a_m_tlast;
    assign o_m_tkeep  = sel ? b_m_tkeep  : a_m_tkeep;
    assign o_m_tdata  = sel ? b_m_tdata  : a_m_tdata;

    always #5 clk = ~clk;

    axis_ifft_sample_serializer #(.FRAMES_PER_PACKET(16)) u_dut_a (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (a_s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (a_m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (a_m_tdata),
        .m_axis_tlast  (a_m_tlast),
        .m_axis_tkeep  (a_m_tkeep)
    );

    axis_ifft_sample_serializer #(.FRAMES_PER_PACKET(1)) u_dut_b (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (b_s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (b_m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (b_m_tdata),
        .m_axis_tlast  (b_m_tlast),
        .m_axis_tkeep  (b_m_tkeep)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of expected samples in emission order
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       eow;    // final sample of its word
    } smp_t;

    smp_t       exp_q[$];
    int         fpp = 16;
    int         words_acc, resident, since_rst, beats_total;
    int         tlast_count, last_idx, cyc, first_beat_cyc, last_beat_cyc;
    int         blocked_count;
    bit         last_in_fire, prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [7:0] conv(input logic [7:0] s);
`ifdef IFFT_SERIALIZER_OFFSET_BINARY_EN
        return s ^ 8'h80;
`else
        return s;
`endif
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        words_acc      = 0;
        resident       = 0;
        since_rst      = 0;
        beats_total    = 0;
        tlast_count    = 0;
        last_idx       = -1;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
        blocked_count  = 0;
        last_in_fire   = 1'b0;
        prev_stall     = 1'b0;
    endtask

    // Check the current cycle against the model, account for the
    // handshakes that happen at the coming edge, then advance one cycle.
    task automatic step();
        bit   in_fire, out_fire;
        smp_t s;
        in_fire  = s_tvalid && o_s_tready;
        out_fire = o_m_tvalid && m_tready;

        chk("m_tvalid", o_m_tvalid, exp_q.size() != 0);
        if (since_rst >= 1)
            chk("s_tready", o_s_tready, resident < 2);
        if (prev_stall) begin
            chk("stall_tdata", o_m_tdata, prev_data);
            chk("stall_tlast", o_m_tlast, prev_last);
        end
        if (s_tvalid && !o_s_tready && since_rst >= 1)
            blocked_count++;

        if (out_fire) begin
            if (exp_q.size() == 0) begin
                fail_now("extra_beat");
            end else begin
                s = exp_q.pop_front();
                chk("tdata", o_m_tdata, s.data);
                chk("tlast", o_m_tlast, s.last);
                if (s.eow) resident--;
            end
            if (o_m_tlast) begin
                tlast_count++;
                last_idx = beats_total;
            end
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beats_total++;
        end

        if (in_fire) begin
            for (int k = 0; k < 8; k++) begin
                s.data = conv(s_tdata[8*k +: 8]);
                s.eow  = (k == 7);
                s.last = (k == 7) && ((words_acc % fpp) == fpp - 1);
                exp_q.push_back(s);
            end
            words_acc++;
            resident++;
        end

        last_in_fire = in_fire;
        prev_stall   = o_m_tvalid && !m_tready;
        prev_data    = o_m_tdata;
        prev_last    = o_m_tlast;
        @(posedge clk);
        #1;
        cyc++;
        since_rst++;
    endtask

    // Called 1 time unit after a rising edge.
    task automatic apply_reset();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        rst      = 1'b1;
        #2;
        chk("rst_m_tvalid", o_m_tvalid, 0);
        chk("rst_m_tdata",  o_m_tdata,  0);
        chk("rst_m_tlast",  o_m_tlast,  0);
        chk("rst_s_tready", o_s_tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic drain(input bit toggle, input int budget);
        int n = 0;
        s_tvalid = 1'b0;
        while (exp_q.size() != 0 && n < budget) begin
            m_tready = toggle ? ~m_tready : 1'b1;
            step();
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        m_tready = 1'b1;
        step();
        step();
    endtask

    task automatic send_words(input int n, input bit toggle, input int budget);
        int target = words_acc + n;
        int c = 0;
        s_tvalid = 1'b1;
        s_tdata  = rand64();
        while (words_acc < target && c < budget) begin
            m_tready = toggle ? ~m_tready : 1'b1;
            step();
            c++;
            if (last_in_fire) begin
                if (words_acc < target) s_tdata = rand64();
                else s_tvalid = 1'b0;
            end
        end
        if (words_acc < target) fail_now("send_timeout");
        drain(toggle, 64 * n + 64);
    endtask

    task automatic random_run(input int n, input int budget);
        int c = 0;
        s_tvalid = 1'b0;
        while ((words_acc < n || exp_q.size() != 0) && c < budget) begin
            if (!s_tvalid && words_acc < n && $urandom_range(0, 3) != 0) begin
                s_tvalid = 1'b1;
                s_tdata  = rand64();
            end
            m_tready = ($urandom_range(0, 2) != 0);
            step();
            c++;
            if (last_in_fire) s_tvalid = 1'b0;
        end
        if (c >= budget) fail_now("random_timeout");
        s_tvalid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: expected bytes in emission order, MSB first
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] word;
        logic [63:0] exp_raw;
        logic [63:0] exp_ofs;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [63:0] exp_bytes;
        int          n;

        vecs[0] = '{64'h0706_0504_0302_0100, 64'h00_01_02_03_04_05_06_07, 64'h80_81_82_83_84_85_86_87};
        vecs[1] = '{64'h7F00_80FF_0102_FE01, 64'h01_FE_02_01_FF_80_00_7F, 64'h81_7E_82_81_7F_00_80_FF};
        vecs[2] = '{64'h80FF_7F01_55AA_C33C, 64'h3C_C3_AA_55_01_7F_FF_80, 64'hBC_43_2A_D5_81_FF_7F_00};

        model_clear();
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        chk("tkeep", o_m_tkeep, 1);

        // Single words, ready=1: x0..x7 on consecutive cycles, one cycle after accept.
        for (int v = 0; v < 3; v++) begin
`ifdef IFFT_SERIALIZER_OFFSET_BINARY_EN
            exp_bytes = vecs[v].exp_ofs;
`else
            exp_bytes = vecs[v].exp_raw;
`endif
            m_tready = 1'b1;
            s_tvalid = 1'b1;
            s_tdata  = vecs[v].word;
            n = 0;
            while (!o_s_tready && n < 20) begin
                step();
                n++;
            end
            if (!o_s_tready) fail_now("vec_accept_timeout");
            step();
            s_tvalid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("vec%0d_valid%0d", v, k), o_m_tvalid, 1);
                chk($sformatf("vec%0d_byte%0d", v, k), o_m_tdata, exp_bytes[63-8*k -: 8]);
                chk($sformatf("vec%0d_last%0d", v, k), o_m_tlast, 0);
                step();
            end
            step();
        end

        // 16 back-to-back words: 128 gapless beats, tlast only on beat 127.
        apply_reset();
        send_words(16, 1'b0, 400);
        chk("b2b_beats", beats_total, 128);
        chk("b2b_tlast_count", tlast_count, 1);
        chk("b2b_tlast_idx", last_idx, 127);
        chk("b2b_span", last_beat_cyc - first_beat_cyc + 1, 128);

        // Output ready toggling: order kept, stalls stable, input back-pressured.
        apply_reset();
        m_tready = 1'b0;
        send_words(4, 1'b1, 400);
        chk("toggle_beats", beats_total, 32);
        chk("toggle_hold_full_seen", blocked_count != 0, 1);

        // Reset while sample 3 of word 2 is on the bus.
        apply_reset();
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = rand64();
        n = 0;
        while (beats_total != 19 && n < 200) begin
            step();
            n++;
            if (last_in_fire) s_tdata = rand64();
        end
        if (beats_total != 19) fail_now("midword_reach_timeout");
        chk("midword_valid_before_rst", o_m_tvalid, 1);
        apply_reset();
        send_words(16, 1'b0, 400);
        chk("post_rst_beats", beats_total, 128);
        chk("post_rst_tlast_count", tlast_count, 1);
        chk("post_rst_tlast_idx", last_idx, 127);

        // Random valid/ready, FRAMES_PER_PACKET = 16.
        apply_reset();
        random_run(208, 8000);
        chk("rand16_beats", beats_total, 208 * 8);
        chk("rand16_tlast_count", tlast_count, 13);
        chk("rand16_left", exp_q.size(), 0);

        // Random valid/ready, FRAMES_PER_PACKET = 1: tlast on every word.
        sel = 1'b1;
        fpp = 1;
        apply_reset();
        random_run(1500, 40000);
        chk("rand1_beats", beats_total, 1500 * 8);
        chk("rand1_tlast_count", tlast_count, 1500);
        chk("rand1_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_axis_ifft_sample_serializer
`default_nettype wire
